fu_issue_ctrl: RTL and testbench
================================

// Module: fu_issue_ctrl
// PURPOSE
//  Issue/writeback controller directly downstream of the priority decoder in the rv32imf execute stage.
//  Takes the decoder's one-hot 9-bit unit select and gates it into unit start pulses.
//  Tracks a writeback-slot reservation table for the fixed-latency units and busy flags for the multi-cycle units.
//  Raises stall on data or structural hazards and drives a one-hot writeback grant for the single shared result port.
// PARAMETERS
//  LAT_FADD  3  cycles from start to writeback, f_add_sub unit (bit 5); must be >=1
//  LAT_FMUL  3  cycles, f_mul unit (bit 4); must be >=1
//  LAT_R4    5  cycles, fused multiply-add unit (bit 3); must be >=1
//  (bits 8:6 alu/fpu/mul: fixed latency 1)
//  MAX_LAT = max(1, LAT_FADD, LAT_FMUL, LAT_R4)  (localparam)
// PORTS
//  clk            in   1  core clock
//  reset_n        in   1  synchronous active-low reset
//  issue_valid    in   1  decoded instruction present in this cycle
//  p_signal_start in   9  one-hot unit select: [8]alu [7]fpu [6]mul [5]fadd [4]fmul [3]r4 [2]fdiv [1]div [0]fsqrt
//  rd_busy        in   1  data-dependency hazard on rd/rs
//  mc_done        in   3  {fdiv,div,fsqrt} result ready; held high until granted
//  unit_start     out  9  one-cycle start pulse to the selected unit
//  stall          out  1  hold the decode/issue stage this cycle (combinational)
//  wb_sel         out  9  one-hot writeback grant, same bit order; all-zero means no writeback
//  mc_busy        out  3  {fdiv,div,fsqrt} occupied
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): clear slot table and mc_busy.
//    unit_start, wb_sel and mc_busy read 0; stall = issue_valid & rd_busy.
//    Reset mid-operation drops all in-flight reservations; no writeback grant is issued for them.
//  - Slot table s[1..MAX_LAT], each entry 9-bit one-hot or zero; s[k] means writeback k cycles from now.
//    Every cycle s[k] <= s[k+1], and s[MAX_LAT] <= 0 unless written by a new issue.
//  - Latency L per unit: 1 for bits 8:6, LAT_* for bits 5:3.
//  - stall = issue_valid & (rd_busy | mc_conflict | slot_conflict), where:
//    mc_conflict: selected bit in [2:0] and the matching mc_busy is set.
//    slot_conflict: fixed-latency unit with L<MAX_LAT and s[L+1]!=0; this slot shifts into s[L] and would collide.
//  - Issue fires when issue_valid & ~stall & p_signal_start!=0:
//    unit_start = p_signal_start (combinational, same cycle).
//    Fixed-latency unit: s[L] <= p_signal_start on the next edge.
//    Multi-cycle unit: mc_busy bit set on the next edge.
//  - p_signal_start==0 with issue_valid (branch/store/no unit): no start, no reservation; stall only from rd_busy.
//  - wb_sel (combinational from registers):
//    if s[1]!=0 then wb_sel = s[1]; reserved pipeline results always win.
//    else the highest-priority (mc_done & mc_busy) bit in order fdiv > div > fsqrt; else 0.
//  - A granted multi-cycle bit clears mc_busy on the next edge.
//    The unit is re-issuable the cycle after the grant, not in the grant cycle.
//  - mc_done asserted for a unit whose mc_busy=0 is ignored.
//  - Simultaneous events:
//    Issue and s[1] writeback in the same cycle are both legal.
//    Issue to a multi-cycle unit in its own grant cycle stalls.
//  - Illegal: more than one bit of p_signal_start set; covered by an assertion, behaviour undefined.
//  - Throughput: one issue per cycle when there are no hazards. Latency: start at cycle t -> wb_sel at t+L.
// CONFIGURATION
//  ISSUE_PERF_CNT_EN defined:
//    Adds out ports perf_issue_cnt[31:0] (+1 per fired issue) and perf_stall_cnt[31:0] (+1 per stall cycle).
//    Both reset to 0, wrap at 2^32, saturate never.
//  ISSUE_PERF_CNT_EN undefined: ports and counters are absent; no other behaviour changes.
// TESTING
//  1 Reset: reset_n=0 for 2 cycles mid-stream with fdiv busy -> mc_busy=0, wb_sel=0, no later grant for the dropped ops.
//  2 Latency: issue 9'h020 (fadd) at t -> unit_start=9'h020 at t, wb_sel=9'h020 at t+3 only; issue alu 9'h100 -> wb at t+1.
//  3 Slot conflict: fadd (L=3) at t, then fmul (L=3) at t+1 -> no stall.
//    fadd at t, then alu at t+2 (s[2] occupied) -> stall=1 at t+2, alu issues at t+3.
//  4 Multi-cycle:
//    div 9'h002 at t, div again at t+1 -> stall until grant.
//    mc_done=3'b010 while s[1]!=0 -> wb_sel=s[1], and div is granted the next free cycle.
//  5 mc priority: mc_done=3'b111 with all busy, table empty -> wb_sel 9'h004, 9'h002, 9'h001 on consecutive cycles.
//  6 rd_busy=1 with issue_valid, select 9'h100 -> stall=1, unit_start=0.
//    With ISSUE_PERF_CNT_EN: perf_stall_cnt +1 per cycle, perf_issue_cnt unchanged.

Source files
------------

// File: rtl/fu_issue_ctrl.sv
// Issue/writeback controller for the rv32imf execute stage: gates unit starts, books result-port slots, arbitrates writeback.
// Optional performance counters are enabled with the ISSUE_PERF_CNT_EN macro.
module fu_issue_ctrl #(
  parameter int LAT_FADD = 3,
  parameter int LAT_FMUL = 3,
  parameter int LAT_R4   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [8:0]  p_signal_start,
  input  logic        rd_busy,
  input  logic [2:0]  mc_done,
  output logic [8:0]  unit_start,
  output logic        stall,
  output logic [8:0]  wb_sel,
  output logic [2:0]  mc_busy
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int MAX_FP  = (LAT_FADD > LAT_FMUL) ? LAT_FADD : LAT_FMUL;
  localparam int MAX_FP3 = (MAX_FP > LAT_R4) ? MAX_FP : LAT_R4;
  localparam int MAX_LAT = (MAX_FP3 > 1) ? MAX_FP3 : 1;
  localparam int LW      = $clog2(MAX_LAT + 1);

  // slot_q[k] holds the unit whose result owns the shared port k-1 cycles after this one.
  logic [8:0]    slot_q [1:MAX_LAT];
  logic [8:0]    slot_d [1:MAX_LAT];
  logic [2:0]    busy_q;
  logic [2:0]    busy_d;

  logic          fixed_sel;
  logic [2:0]    mc_sel;
  logic [LW-1:0] issue_lat;
  logic          slot_conflict;
  logic          mc_conflict;
  logic          fire;
  logic [2:0]    mc_ready;
  logic [2:0]    mc_grant;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fixed_sel     = |p_signal_start[8:3];
    mc_sel        = p_signal_start[2:0];
    issue_lat     = LW'(1);
    slot_conflict = 1'b0;
    mc_conflict   = 1'b0;
    stall         = 1'b0;
    fire          = 1'b0;
    unit_start    = '0;
    mc_ready      = '0;
    mc_grant      = '0;
    wb_sel        = '0;
    mc_busy       = '0;

    if (p_signal_start[5])      issue_lat = LW'(LAT_FADD);
    else if (p_signal_start[4]) issue_lat = LW'(LAT_FMUL);
    else if (p_signal_start[3]) issue_lat = LW'(LAT_R4);

    // The entry one beyond the target slot shifts into it at the next edge.
    for (int k = 1; k < MAX_LAT; k++) begin
      if (fixed_sel && (issue_lat == LW'(k)) && (slot_q[k+1] != '0)) slot_conflict = 1'b1;
    end
    mc_conflict = |(mc_sel & busy_q);

    stall      = issue_valid & (rd_busy | (reset_n & (mc_conflict | slot_conflict)));
    fire       = reset_n & issue_valid & ~stall & (p_signal_start != '0);
    unit_start = fire ? p_signal_start : '0;

    if (reset_n) begin
      mc_busy  = busy_q;
      mc_ready = mc_done & busy_q;
      if (slot_q[1] != '0) begin
        wb_sel = slot_q[1];
      end else begin
        if (mc_ready[2])      mc_grant = 3'b100;
        else if (mc_ready[1]) mc_grant = 3'b010;
        else if (mc_ready[0]) mc_grant = 3'b001;
        wb_sel = {6'b0, mc_grant};
      end
    end
  end

  always_comb begin
    for (int k = 1; k < MAX_LAT; k++) slot_d[k] = slot_q[k+1];
    slot_d[MAX_LAT] = '0;
    if (fire && fixed_sel) begin
      for (int k = 1; k <= MAX_LAT; k++) begin
        if (issue_lat == LW'(k)) slot_d[k] = p_signal_start;
      end
    end
    busy_d = (busy_q & ~mc_grant) | (fire ? mc_sel : 3'b000);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the slot table is a handful of flops, not a RAM, so it is reset to drop in-flight bookings.
      for (int k = 1; k <= MAX_LAT; k++) slot_q[k] <= '0;
      busy_q <= '0;
    end else begin
      slot_q <= slot_d;
      busy_q <= busy_d;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_issue_cnt <= perf_issue_cnt + {31'b0, fire};
      perf_stall_cnt <= perf_stall_cnt + {31'b0, stall};
    end
  end
`endif

  a_onehot_select: assert property (@(posedge clk) disable iff (!reset_n)
    issue_valid |-> $onehot0(p_signal_start));

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Self-checking bench for fu_issue_ctrl: directed vector table, hand sequences, and randomized run against a booking-calendar model.
module tb_fu_issue_ctrl;

  localparam int LAT_FADD = 3;
  localparam int LAT_FMUL = 3;
  localparam int LAT_R4   = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       issue_valid;
  logic [8:0] p_signal_start;
  logic       rd_busy;
  logic [2:0] mc_done;
  logic [8:0] unit_start;
  logic       stall;
  logic [8:0] wb_sel;
  logic [2:0] mc_busy;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fu_issue_ctrl #(.LAT_FADD(LAT_FADD), .LAT_FMUL(LAT_FMUL), .LAT_R4(LAT_R4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .issue_valid(issue_valid),
    .p_signal_start(p_signal_start),
    .rd_busy(rd_busy),
    .mc_done(mc_done),
    .unit_start(unit_start),
    .stall(stall),
    .wb_sel(wb_sel),
    .mc_busy(mc_busy)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       iv;
    logic [8:0] p;
    logic       rd;
    logic [8:0] e_start;
    logic       e_stall;
    logic [8:0] e_wb;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [8:0] p,
                       input logic rd, input logic [2:0] done);
    @(negedge clk);
    reset_n        = rst;
    issue_valid    = iv;
    p_signal_start = p;
    rd_busy        = rd;
    mc_done        = done;
    #1;
  endtask

  task automatic step(input string tag, input logic rst, input logic iv, input logic [8:0] p,
                      input logic rd, input logic [2:0] done, input logic [8:0] e_start,
                      input logic e_stall, input logic [8:0] e_wb, input logic [2:0] e_busy);
    drive(rst, iv, p, rd, done);
    check({tag, ".unit_start"}, 32'(unit_start), 32'(e_start));
    check({tag, ".stall"},      32'(stall),      32'(e_stall));
    check({tag, ".wb_sel"},     32'(wb_sel),     32'(e_wb));
    check({tag, ".mc_busy"},    32'(mc_busy),    32'(e_busy));
  endtask

  function automatic vec_t mk(input logic iv, input logic [8:0] p, input logic rd,
                              input logic [8:0] e_start, input logic e_stall, input logic [8:0] e_wb);
    vec_t v;
    v.iv = iv; v.p = p; v.rd = rd;
    v.e_start = e_start; v.e_stall = e_stall; v.e_wb = e_wb;
    return v;
  endfunction

  // Reference model state: result-port bookings indexed by absolute cycle.
  logic [8:0]  booked [16];
  logic [2:0]  m_busy, m_dflag, m_grant, m_ready;
  int unsigned m_iss, m_stl;
  logic        r_rst, r_iv, r_rd, r_fixed, r_conf, r_mcc, r_fire;
  logic [8:0]  r_p, x_start, x_wb;
  logic        x_stall;
  logic [2:0]  x_busy, r_done;
  int          r_lat, r_idx, r_slot;

  initial begin
    reset_n = 1'b0; issue_valid = 1'b0; p_signal_start = '0; rd_busy = 1'b0; mc_done = '0;
    repeat (3) @(posedge clk);

    step("rst_idle", 1'b0, 1'b1, 9'h000, 1'b1, 3'b000, 9'h000, 1'b1, 9'h000, 3'b000);

    // Directed per-cycle vectors: latency, slot conflicts, rd_busy, max-latency unit.
    tbl.push_back(mk(1, 9'h020, 0, 9'h020, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h020));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(1, 9'h100, 0, 9'h100, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h100));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(1, 9'h020, 0, 9'h020, 0, 9'h000));
    tbl.push_back(mk(1, 9'h010, 0, 9'h010, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h020));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h010));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(1, 9'h020, 0, 9'h020, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(1, 9'h100, 0, 9'h000, 1, 9'h000));
    tbl.push_back(mk(1, 9'h100, 0, 9'h100, 0, 9'h020));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h100));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(1, 9'h100, 1, 9'h000, 1, 9'h000));
    tbl.push_back(mk(1, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(1, 9'h000, 1, 9'h000, 1, 9'h000));
    tbl.push_back(mk(1, 9'h008, 0, 9'h008, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    tbl.push_back(mk(1, 9'h100, 0, 9'h000, 1, 9'h000));
    tbl.push_back(mk(1, 9'h100, 0, 9'h100, 0, 9'h008));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h100));
    tbl.push_back(mk(0, 9'h000, 0, 9'h000, 0, 9'h000));
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("tbl%0d", i), 1'b1, tbl[i].iv, tbl[i].p, tbl[i].rd, 3'b000,
           tbl[i].e_start, tbl[i].e_stall, tbl[i].e_wb, 3'b000);

    // Multi-cycle div: re-issue stalls until the grant, grant yields to a booked slot.
    step("div0", 1, 1, 9'h002, 0, 3'b000, 9'h002, 0, 9'h000, 3'b000);
    step("div1", 1, 1, 9'h002, 0, 3'b000, 9'h000, 1, 9'h000, 3'b010);
    step("div2", 1, 1, 9'h002, 0, 3'b000, 9'h000, 1, 9'h000, 3'b010);
    step("div3", 1, 1, 9'h002, 0, 3'b010, 9'h000, 1, 9'h002, 3'b010);
    step("div4", 1, 1, 9'h002, 0, 3'b000, 9'h002, 0, 9'h000, 3'b000);
    step("div5", 1, 1, 9'h100, 0, 3'b000, 9'h100, 0, 9'h000, 3'b010);
    step("div6", 1, 0, 9'h000, 0, 3'b010, 9'h000, 0, 9'h100, 3'b010);
    step("div7", 1, 0, 9'h000, 0, 3'b010, 9'h000, 0, 9'h002, 3'b010);
    step("div8", 1, 0, 9'h000, 0, 3'b000, 9'h000, 0, 9'h000, 3'b000);

    // Multi-cycle priority fdiv > div > fsqrt.
    step("pri0", 1, 1, 9'h004, 0, 3'b000, 9'h004, 0, 9'h000, 3'b000);
    step("pri1", 1, 1, 9'h002, 0, 3'b000, 9'h002, 0, 9'h000, 3'b100);
    step("pri2", 1, 1, 9'h001, 0, 3'b000, 9'h001, 0, 9'h000, 3'b110);
    step("pri3", 1, 0, 9'h000, 0, 3'b111, 9'h000, 0, 9'h004, 3'b111);
    step("pri4", 1, 0, 9'h000, 0, 3'b111, 9'h000, 0, 9'h002, 3'b011);
    step("pri5", 1, 0, 9'h000, 0, 3'b111, 9'h000, 0, 9'h001, 3'b001);
    step("pri6", 1, 0, 9'h000, 0, 3'b111, 9'h000, 0, 9'h000, 3'b000);
    step("pri7", 1, 0, 9'h000, 0, 3'b000, 9'h000, 0, 9'h000, 3'b000);

    // Reset mid-stream with fdiv busy and an fadd in flight.
    step("mrst0", 1, 1, 9'h004, 0, 3'b000, 9'h004, 0, 9'h000, 3'b000);
    step("mrst1", 1, 1, 9'h020, 0, 3'b000, 9'h020, 0, 9'h000, 3'b100);
    step("mrst2", 0, 1, 9'h000, 1, 3'b000, 9'h000, 1, 9'h000, 3'b000);
    step("mrst3", 0, 1, 9'h004, 0, 3'b000, 9'h000, 0, 9'h000, 3'b000);
    step("mrst4", 1, 0, 9'h000, 0, 3'b100, 9'h000, 0, 9'h000, 3'b000);
    step("mrst5", 1, 0, 9'h000, 0, 3'b100, 9'h000, 0, 9'h000, 3'b000);
    step("mrst6", 1, 0, 9'h000, 0, 3'b000, 9'h000, 0, 9'h000, 3'b000);
    step("mrst7", 1, 1, 9'h004, 0, 3'b000, 9'h004, 0, 9'h000, 3'b000);
    step("mrst8", 1, 0, 9'h000, 0, 3'b000, 9'h000, 0, 9'h000, 3'b100);
    step("mrst9", 1, 0, 9'h000, 0, 3'b100, 9'h000, 0, 9'h004, 3'b100);
    step("mrst10", 1, 0, 9'h000, 0, 3'b000, 9'h000, 0, 9'h000, 3'b000);

    // Randomized run against the booking-calendar model.
    drive(1'b0, 1'b0, 9'h000, 1'b0, 3'b000);
    for (int i = 0; i < 16; i++) booked[i] = '0;
    m_busy = '0; m_dflag = '0; m_iss = 0; m_stl = 0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = (c < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
      r_iv  = ($urandom_range(0, 3) != 0);
      r_rd  = ($urandom_range(0, 7) == 0);
      r_idx = int'($urandom_range(0, 10));
      r_p   = (r_idx < 9) ? 9'(1 << r_idx) : 9'h000;
      for (int b = 0; b < 3; b++)
        if (m_busy[b] && !m_dflag[b] && ($urandom_range(0, 3) == 0)) m_dflag[b] = 1'b1;
      r_done = m_dflag | (3'($urandom_range(0, 7)) & ~m_busy);
      drive(r_rst, r_iv, r_p, r_rd, r_done);

      r_slot  = c % 16;
      r_lat   = r_p[5] ? LAT_FADD : r_p[4] ? LAT_FMUL : r_p[3] ? LAT_R4 : 1;
      r_fixed = |r_p[8:3];
      m_grant = '0;
      r_fire  = 1'b0;
      if (!r_rst) begin
        x_start = '0; x_wb = '0; x_busy = '0; x_stall = r_iv & r_rd;
      end else begin
        r_conf  = r_fixed && (booked[(c + r_lat) % 16] != '0);
        r_mcc   = |(r_p[2:0] & m_busy);
        x_stall = r_iv & (r_rd | r_conf | r_mcc);
        r_fire  = r_iv & ~x_stall & (r_p != '0);
        x_start = r_fire ? r_p : '0;
        if (booked[r_slot] != '0) begin
          x_wb = booked[r_slot];
        end else begin
          m_ready = r_done & m_busy;
          if (m_ready[2])      m_grant = 3'b100;
          else if (m_ready[1]) m_grant = 3'b010;
          else if (m_ready[0]) m_grant = 3'b001;
          x_wb = {6'b0, m_grant};
        end
        x_busy = m_busy;
      end

      check("rnd.unit_start", 32'(unit_start), 32'(x_start));
      check("rnd.stall",      32'(stall),      32'(x_stall));
      check("rnd.wb_sel",     32'(wb_sel),     32'(x_wb));
      check("rnd.mc_busy",    32'(mc_busy),    32'(x_busy));
`ifdef ISSUE_PERF_CNT_EN
      check("rnd.perf_issue_cnt", perf_issue_cnt, m_iss);
      check("rnd.perf_stall_cnt", perf_stall_cnt, m_stl);
`endif

      if (!r_rst) begin
        for (int i = 0; i < 16; i++) booked[i] = '0;
        m_busy = '0; m_dflag = '0; m_iss = 0; m_stl = 0;
      end else begin
        booked[r_slot] = '0;
        if (r_fire && r_fixed) booked[(c + r_lat) % 16] = r_p;
        if (r_fire) m_busy = m_busy | r_p[2:0];
        m_busy  = m_busy & ~m_grant;
        m_dflag = m_dflag & ~m_grant;
        m_iss   = m_iss + 32'(r_fire);
        m_stl   = m_stl + 32'(x_stall);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
